i2c_slave_reg_bridge: RTL
=========================

Name: i2c_slave_reg_bridge

Overview:
- I2C slave that turns bus transactions into a simple parallel register read/write interface for FPGA fabric.
- Attaches to one slave-side IIC port of the on-chip I2C interconnect through scl_i/o/t and sda_i/o/t.
- Lets external or internal I2C masters reach fabric registers on the same bus as other I2C devices.
- Never stretches the clock; drives SDA only to pull it low.

Parameters:
- I2C_ADDR, 7'h3C, 7-bit slave address the block responds to.
- AW, 8, register pointer width; the pointer wraps at 2^AW.
- FILT_LEN, 4, consecutive equal samples needed to accept a new level on the synchronised SCL/SDA (glitch filter).

Ports:
- clk  in  1  system clock; the only clock; must be at least 20x SCL.
- rst_n  in  1  asynchronous, active-low reset.
- scl_i  in  1  SCL bus level.
- scl_o  out  1  SCL output value; constant 0.
- scl_t  out  1  SCL tristate (1 = released); constant 1.
- sda_i  in  1  SDA bus level.
- sda_o  out  1  SDA output value; constant 0.
- sda_t  out  1  SDA tristate; 0 only while pulling SDA low.
- wr_strb  out  1  one-clk pulse: register write.
- wr_addr  out  AW  write register address; valid with wr_strb.
- wr_data  out  8  write data; valid with wr_strb.
- rd_addr  out  AW  current read pointer.
- rd_data  in  8  fabric data for rd_addr; combinational or stable within 1 clk.
- busy  out  1  high from an accepted address match until STOP.

Behaviour:
- Input conditioning: scl_i/sda_i pass through a 2-FF synchroniser, then the FILT_LEN filter; all logic uses the filtered levels. Edge detect: rise/fall pulses on filtered SCL.
- Bus conditions:
  - START (incl. repeated): filtered SDA falls while SCL high. Enters ADDR from any state and clears the bit counter.
  - STOP: filtered SDA rises while SCL high. Enters IDLE from any state, sets sda_t=1 the next clk, clears busy.
- Bit timing: sample SDA on SCL rise. Change sda_t only on SCL fall.
- States and transitions:
  - IDLE: SDA released; wait for START.
  - ADDR: shift 8 bits MSB first. On the 8th rise, compare the upper 7 bits to I2C_ADDR. Match → ADDR_ACK with the R/W bit latched. Mismatch → IDLE; never ACK.
  - ADDR_ACK: pull SDA low from the next SCL fall for one SCL period; set busy. Write → PTR; read → load the read shift register from rd_data at the ACK-ending fall, then RD_DATA.
  - PTR: 8 bits into pointer[AW-1:0]; extra MSBs are discarded when AW<8. → PTR_ACK (ACK) → WR_DATA.
  - WR_DATA: on the 8th rise, wr_strb=1 for exactly one clk with wr_addr=pointer, wr_data=byte; pointer increments the next clk, wrapping 2^AW-1→0. → WR_ACK (ACK) → WR_DATA.
  - RD_DATA: drive the byte MSB first (sda_t=~bit) on the 8 SCL falls. Release SDA at the 8th-bit-ending fall. → RD_ACK.
  - RD_ACK: sample master ACK on SCL rise. ACK (0): pointer+1 (wrap), reload from rd_data at the following fall, → RD_DATA. NACK (1): → IDLE, SDA stays released.
- Pointer persistence: the pointer persists across transactions, so write-PTR, repeated START, then read returns from PTR.
- rd_addr always equals the pointer.
- Reset (asynchronous, any time, including mid-byte):
  - Outputs: sda_t=1, scl_t=1, sda_o=0, scl_o=0, wr_strb=0, busy=0, wr_addr=0, wr_data=0.
  - Internal: pointer=0, state IDLE, filters preset to 1 (bus idle).
- No SCL activity: state holds indefinitely; no timeout.
- Simultaneous START/STOP with a byte-complete rise: the bus condition wins and no wr_strb is issued for the partial byte.

Test Plan:
- Reset → all outputs at reset values; write 0x3C/W, ptr 0x10, data 0xA5, 0x5A, STOP → ACK on addr, ptr and both data bytes; wr_strb pulses (0x10,0xA5) then (0x11,0x5A); busy low after STOP.
- Address 0x3D/W → SDA never pulled low; no wr_strb; busy stays 0; a following 0x3C transaction is accepted normally.
- Write ptr 0x20, repeated START, 0x3C/R, 3 bytes with ACK,ACK,NACK; fabric rd_data=~rd_addr → bus bytes 0xDF,0xDE,0xDD; SDA released after NACK.
- Pointer wrap: AW=8, ptr 0xFF, write 2 bytes → wr_addr 0xFF then 0x00.
- Glitch: 2-clk SDA low pulse while SCL high (FILT_LEN=4) → no START detected; state unchanged.
- rst_n asserted while the block drives a read bit low → sda_t=1 immediately (asynchronous); after release, the block is idle with ptr=0 and answers the next valid transaction.

Source files
------------

// File: rtl/i2c_slave_reg_bridge.sv
// ---------------------------------------------------------------------------
// i2c_slave_reg_bridge
//
// I2C slave that maps bus transactions onto a parallel register interface.
// Write transfer: [addr/W] [pointer] [data]* -> one wr_strb per data byte,
// pointer auto-increments. Read transfer: [addr/R] [data]* from rd_data at
// rd_addr, pointer increments on every master ACK. The pointer persists
// across transactions. SCL is never stretched; SDA is only ever pulled low.
//
// Ports
//   clk, rst_n          system clock (>= 20x SCL), async active-low reset
//   scl_i/scl_o/scl_t   SCL pad: level in, constant 0 out, always released
//   sda_i/sda_o/sda_t   SDA pad: level in, constant 0 out, 0 = pull low
//   wr_strb             one-clk write pulse, wr_addr/wr_data valid with it
//   rd_addr/rd_data     current pointer and the fabric data at it
//   busy                high from an address match until STOP
// ---------------------------------------------------------------------------
module i2c_slave_reg_bridge #(
    parameter logic [6:0] I2C_ADDR = 7'h3C,
    parameter int         AW       = 8,
    parameter int         FILT_LEN = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          scl_i,
    output logic          scl_o,
    output logic          scl_t,
    input  logic          sda_i,
    output logic          sda_o,
    output logic          sda_t,
    output logic          wr_strb,
    output logic [AW-1:0] wr_addr,
    output logic [7:0]    wr_data,
    output logic [AW-1:0] rd_addr,
    input  logic [7:0]    rd_data,
    output logic          busy
);

    localparam int            CW      = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(FILT_LEN - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
        S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACK
    } state_t;

    // 2-FF synchronisers
    logic r_scl_p0, r_scl_p1, r_sda_p0, r_sda_p1;
    // glitch filters and previous filtered level for edge detection
    logic          r_scl_f, r_sda_f, r_scl_q, r_sda_q;
    logic [CW-1:0] r_scl_cnt, r_sda_cnt;

    state_t        r_state;
    logic [2:0]    r_bitcnt;
    logic [6:0]    r_shift;
    logic [6:0]    r_rd_shift;
    logic          r_rw;
    logic          r_ack_drv;
    logic          r_mack;
    logic [AW-1:0] r_ptr;
    logic          r_ptr_inc;
    logic          r_sda_t;
    logic          r_busy;
    logic          r_wr_strb;
    logic [AW-1:0] r_wr_addr;
    logic [7:0]    r_wr_data;

    logic       w_scl_rise, w_scl_fall, w_sda_rise, w_sda_fall;
    logic       w_start, w_stop;
    logic [7:0] w_byte;

    // ---- stage: synchronise ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scl_p0 <= 1'b1;
            r_scl_p1 <= 1'b1;
            r_sda_p0 <= 1'b1;
            r_sda_p1 <= 1'b1;
        end else begin
            r_scl_p0 <= scl_i;
            r_scl_p1 <= r_scl_p0;
            r_sda_p0 <= sda_i;
            r_sda_p1 <= r_sda_p0;
        end
    end

    // ---- stage: filter ----
    // A new level is accepted only after FILT_LEN consecutive samples of it;
    // any sample back at the old level restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scl_f   <= 1'b1;
            r_scl_cnt <= '0;
        end else if (r_scl_p1 == r_scl_f) begin
            r_scl_cnt <= '0;
        end else if (r_scl_cnt == CNT_MAX) begin
            r_scl_f   <= r_scl_p1;
            r_scl_cnt <= '0;
        end else begin
            r_scl_cnt <= r_scl_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sda_f   <= 1'b1;
            r_sda_cnt <= '0;
        end else if (r_sda_p1 == r_sda_f) begin
            r_sda_cnt <= '0;
        end else if (r_sda_cnt == CNT_MAX) begin
            r_sda_f   <= r_sda_p1;
            r_sda_cnt <= '0;
        end else begin
            r_sda_cnt <= r_sda_cnt + 1'b1;
        end
    end

    // ---- stage: edge detect ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scl_q <= 1'b1;
            r_sda_q <= 1'b1;
        end else begin
            r_scl_q <= r_scl_f;
            r_sda_q <= r_sda_f;
        end
    end

    assign w_scl_rise = r_scl_f & ~r_scl_q;
    assign w_scl_fall = ~r_scl_f & r_scl_q;
    assign w_sda_rise = r_sda_f & ~r_sda_q;
    assign w_sda_fall = ~r_sda_f & r_sda_q;
    // SCL must have been high on both sides of the SDA edge
    assign w_start    = w_sda_fall & r_scl_f & r_scl_q;
    assign w_stop     = w_sda_rise & r_scl_f & r_scl_q;
    // byte completed by the bit sampled on the current rise
    assign w_byte     = {r_shift, r_sda_f};

    // ---- stage: protocol FSM ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_bitcnt   <= '0;
            r_shift    <= '0;
            r_rd_shift <= '0;
            r_rw       <= 1'b0;
            r_ack_drv  <= 1'b0;
            r_mack     <= 1'b0;
            r_ptr      <= '0;
            r_ptr_inc  <= 1'b0;
            r_sda_t    <= 1'b1;
            r_busy     <= 1'b0;
            r_wr_strb  <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
        end else begin
            r_wr_strb <= 1'b0;
            r_ptr_inc <= 1'b0;
            // post-write increment lands the clk after wr_strb
            if (r_ptr_inc) begin
                r_ptr <= r_ptr + 1'b1;
            end

            // bus conditions override any byte in progress
            if (w_stop) begin
                r_state   <= S_IDLE;
                r_sda_t   <= 1'b1;
                r_busy    <= 1'b0;
                r_ack_drv <= 1'b0;
                r_mack    <= 1'b0;
            end else if (w_start) begin
                r_state   <= S_ADDR;
                r_bitcnt  <= '0;
                r_sda_t   <= 1'b1;
                r_ack_drv <= 1'b0;
                r_mack    <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                    end

                    S_ADDR: begin
                        if (w_scl_rise) begin
                            r_shift  <= w_byte[6:0];
                            r_bitcnt <= r_bitcnt + 1'b1;
                            if (r_bitcnt == 3'd7) begin
                                if (w_byte[7:1] == I2C_ADDR) begin
                                    r_state <= S_ADDR_ACK;
                                    r_rw    <= w_byte[0];
                                    r_busy  <= 1'b1;
                                end else begin
                                    r_state <= S_IDLE;
                                end
                            end
                        end
                    end

                    // First fall after the byte starts the ACK bit, the
                    // next fall ends it.
                    S_ADDR_ACK, S_PTR_ACK, S_WR_ACK: begin
                        if (w_scl_fall) begin
                            if (!r_ack_drv) begin
                                r_sda_t   <= 1'b0;
                                r_ack_drv <= 1'b1;
                            end else begin
                                r_ack_drv <= 1'b0;
                                r_bitcnt  <= '0;
                                if (r_state == S_ADDR_ACK && r_rw) begin
                                    r_rd_shift <= rd_data[6:0];
                                    r_sda_t    <= rd_data[7];
                                    r_state    <= S_RD_DATA;
                                end else begin
                                    r_sda_t <= 1'b1;
                                    r_state <= (r_state == S_ADDR_ACK) ? S_PTR : S_WR_DATA;
                                end
                            end
                        end
                    end

                    S_PTR: begin
                        if (w_scl_rise) begin
                            r_shift  <= w_byte[6:0];
                            r_bitcnt <= r_bitcnt + 1'b1;
                            if (r_bitcnt == 3'd7) begin
                                r_ptr   <= AW'(w_byte);
                                r_state <= S_PTR_ACK;
                            end
                        end
                    end

                    S_WR_DATA: begin
                        if (w_scl_rise) begin
                            r_shift  <= w_byte[6:0];
                            r_bitcnt <= r_bitcnt + 1'b1;
                            if (r_bitcnt == 3'd7) begin
                                r_wr_strb <= 1'b1;
                                r_wr_addr <= r_ptr;
                                r_wr_data <= w_byte;
                                r_ptr_inc <= 1'b1;
                                r_state   <= S_WR_ACK;
                            end
                        end
                    end

                    // MSB was put out at the entering fall; the remaining
                    // seven bits follow on falls, a '1' simply releases SDA.
                    S_RD_DATA: begin
                        if (w_scl_fall) begin
                            if (r_bitcnt == 3'd7) begin
                                r_sda_t  <= 1'b1;
                                r_bitcnt <= '0;
                                r_mack   <= 1'b0;
                                r_state  <= S_RD_ACK;
                            end else begin
                                r_sda_t    <= r_rd_shift[6];
                                r_rd_shift <= {r_rd_shift[5:0], 1'b0};
                                r_bitcnt   <= r_bitcnt + 1'b1;
                            end
                        end
                    end

                    S_RD_ACK: begin
                        if (w_scl_rise) begin
                            if (!r_sda_f) begin
                                r_ptr  <= r_ptr + 1'b1;
                                r_mack <= 1'b1;
                            end else begin
                                r_state <= S_IDLE;
                            end
                        end else if (w_scl_fall && r_mack) begin
                            r_mack     <= 1'b0;
                            r_rd_shift <= rd_data[6:0];
                            r_sda_t    <= rd_data[7];
                            r_bitcnt   <= '0;
                            r_state    <= S_RD_DATA;
                        end
                    end

                    default: begin
                        r_state <= S_IDLE;
                        r_sda_t <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign scl_o   = 1'b0;
    assign scl_t   = 1'b1;
    assign sda_o   = 1'b0;
    assign sda_t   = r_sda_t;
    assign wr_strb = r_wr_strb;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;
    assign rd_addr = r_ptr;
    assign busy    = r_busy;

endmodule
